// File: rtl/zuc_params.sv
// zuc_params: clear op codes, FSM states and bucket upper bounds
// shared by the histogram generator and its bench.
package zuc_params;

    localparam logic [1:0] HIST_OP_CLEAR_CHID  = 2'd1;
    localparam logic [1:0] HIST_OP_CLEAR_ARRAY = 2'd2;
    localparam logic [1:0] HIST_OP_CLEAR_ALL   = 2'd3;

    localparam int MAX_BKT = 32;

    // Bucket k holds values up to 2**k-1; entry 0 unused, last bucket open-ended.
    localparam logic [31:0] SIZE_BKT [MAX_BKT] = '{
        32'd0,          32'd1,          32'd3,          32'd7,
        32'd15,         32'd31,         32'd63,         32'd127,
        32'd255,        32'd511,        32'd1023,       32'd2047,
        32'd4095,       32'd8191,       32'd16383,      32'd32767,
        32'd65535,      32'd131071,     32'd262143,     32'd524287,
        32'd1048575,    32'd2097151,    32'd4194303,    32'd8388607,
        32'd16777215,   32'd33554431,   32'd67108863,   32'd134217727,
        32'd268435455,  32'd536870911,  32'd1073741823, 32'd2147483647
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_UPD,
        ST_CLR
    } hist_st_e;

endpackage

// File: rtl/zuc_histo_fifo.sv
// zuc_histo_fifo: show-ahead event FIFO with synchronous flush.
module zuc_histo_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop_i && !empty_o) rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/zuc_histo_gen.sv
// zuc_histo_gen: per-channel event histogram with queued updates,
// clear sweeps and a registered host read port.
module zuc_histo_gen
    import zuc_params::*;
#(
    parameter int NUM_CHID   = 16,
    parameter int NUM_BKT    = 16,
    parameter int CNT_W      = 32,
    parameter int VAL_W      = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                                        hist_clk,
    input  logic                                        hist_reset_n,
    input  logic [2:0]                                  hist_id,
    input  logic                                        hist_enable,
    input  logic                                        hist_mode,
    input  logic                                        hist_event,
    input  logic [$clog2(NUM_CHID)-1:0]                 hist_event_chid,
    input  logic [VAL_W-1:0]                            hist_event_value,
    input  logic                                        hist_clear,
    input  logic [1:0]                                  hist_clear_op,
    input  logic [$clog2(NUM_CHID)-1:0]                 hist_clear_chid,
    input  logic [2:0]                                  hist_clear_array,
    input  logic [$clog2(NUM_CHID)+$clog2(NUM_BKT)-1:0] hist_adrs,
    output logic [CNT_W-1:0]                            hist_dout,
    output logic [15:0]                                 hist_drop_cnt,
    output logic                                        hist_busy
);

    localparam int CH_W = $clog2(NUM_CHID);
    localparam int BK_W = $clog2(NUM_BKT);
    localparam int AD_W = CH_W + BK_W;
    localparam int FW   = CH_W + VAL_W;

    hist_st_e          state_q;
    logic              busy_q, first_q, all_q, init_q;
    logic              pend_q, pend_all_q;
    logic [CH_W-1:0]   pend_chid_q;
    logic [AD_W-1:0]   cnt_q, upd_adr_q;
    logic [VAL_W-1:0]  upd_val_q;
    logic [15:0]       drop_q;
    logic [CNT_W-1:0]  mem_q [2**AD_W];
    logic [CNT_W-1:0]  old_q, dout_q;

    logic              flush, ev_req, push, pop, f_empty, f_full;
    logic [FW-1:0]     f_rdata;
    logic [CH_W-1:0]   f_chid;
    logic [VAL_W-1:0]  f_val;
    logic [BK_W-1:0]   f_bkt;
    logic              clr_all_req, clr_hit, clr_accept, sweep_done;
    logic [CNT_W:0]    sum;
    logic [CNT_W-1:0]  upd_wd, wd;
    logic [AD_W-1:0]   wa;
    logic              we;

    assign flush  = (state_q == ST_CLR) && first_q && all_q;
    assign ev_req = hist_enable && hist_event;
    assign push   = ev_req && !f_full && !flush;
    assign pop    = (state_q == ST_IDLE) && !pend_q && !init_q && !f_empty;
    assign {f_chid, f_val} = f_rdata;

    zuc_histo_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (hist_clk),
        .rst_ni  (hist_reset_n),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i ({hist_event_chid, hist_event_value}),
        .pop_i   (pop),
        .rdata_o (f_rdata),
        .empty_o (f_empty),
        .full_o  (f_full)
    );

    // Descending scan so the smallest matching threshold wins.
    always_comb begin
        f_bkt = BK_W'(NUM_BKT-1);
        for (int k = NUM_BKT-2; k >= 1; k--) begin
            if (64'(f_val) <= 64'(SIZE_BKT[k])) f_bkt = BK_W'(k);
        end
        if (f_val == '0) f_bkt = '0;
    end

    assign clr_all_req = (hist_clear_op == HIST_OP_CLEAR_ALL) ||
                         ((hist_clear_op == HIST_OP_CLEAR_ARRAY) &&
                          (hist_clear_array == hist_id));
    assign clr_hit     = hist_clear && (clr_all_req ||
                         ((hist_clear_op == HIST_OP_CLEAR_CHID) &&
                          (hist_clear_array == hist_id)));
    assign clr_accept  = clr_hit && !pend_q && (state_q != ST_CLR);
    assign sweep_done  = all_q ? (cnt_q == '1) : (cnt_q[BK_W-1:0] == '1);

    assign sum    = {1'b0, old_q} +
                    (hist_mode ? (CNT_W+1)'(upd_val_q) : (CNT_W+1)'(1));
    assign upd_wd = sum[CNT_W] ? '1 : sum[CNT_W-1:0];

    always_comb begin
        we = 1'b0;
        wa = upd_adr_q;
        wd = upd_wd;
        if (state_q == ST_CLR) begin
            we = 1'b1;
            wa = cnt_q;
            wd = '0;
        end else if (state_q == ST_UPD) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge hist_clk) begin
        if (we) mem_q[wa] <= wd;
        old_q <= mem_q[upd_adr_q];
    end

    always_ff @(posedge hist_clk or negedge hist_reset_n) begin
        if (!hist_reset_n) dout_q <= '0;
        else dout_q <= (we && (wa == hist_adrs)) ? wd : mem_q[hist_adrs];
    end

    always_ff @(posedge hist_clk or negedge hist_reset_n) begin
        if (!hist_reset_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            first_q     <= 1'b0;
            all_q       <= 1'b0;
            init_q      <= 1'b1;
            pend_q      <= 1'b0;
            pend_all_q  <= 1'b0;
            pend_chid_q <= '0;
            cnt_q       <= '0;
            upd_adr_q   <= '0;
            upd_val_q   <= '0;
            drop_q      <= '0;
        end else begin
            first_q <= 1'b0;
            if (flush) drop_q <= '0;
            else if (ev_req && f_full && (drop_q != 16'hFFFF))
                drop_q <= drop_q + 16'd1;
            unique case (state_q)
                ST_IDLE: begin
                    if (pend_q && !pend_all_q) begin
                        state_q <= ST_CLR;
                        busy_q  <= 1'b1;
                        first_q <= 1'b1;
                        all_q   <= 1'b0;
                        pend_q  <= 1'b0;
                        cnt_q   <= {pend_chid_q, BK_W'(0)};
                    end else if (pend_q || init_q) begin
                        state_q <= ST_CLR;
                        busy_q  <= 1'b1;
                        first_q <= 1'b1;
                        all_q   <= 1'b1;
                        pend_q  <= 1'b0;
                        init_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (!f_empty) begin
                        state_q   <= ST_RD;
                        upd_adr_q <= {f_chid, f_bkt};
                        upd_val_q <= f_val;
                    end
                end
                ST_RD:  state_q <= ST_UPD;
                ST_UPD: state_q <= ST_IDLE;
                ST_CLR: begin
                    cnt_q <= cnt_q + AD_W'(1);
                    if (sweep_done) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Placed last so a clear accepted during a post-reset start is kept.
            if (clr_accept) begin
                pend_q      <= 1'b1;
                pend_all_q  <= clr_all_req;
                pend_chid_q <= hist_clear_chid;
            end
        end
    end

    assign hist_dout     = dout_q;
    assign hist_drop_cnt = drop_q;
    assign hist_busy     = busy_q;

endmodule

// File: tb/tb_zuc_histo_gen.sv
// tb_zuc_histo_gen: directed table-driven checks plus hand-written
// clear/overflow sequences for zuc_histo_gen.
module tb_zuc_histo_gen;
    import zuc_params::*;

    typedef struct {
        logic        mode;
        logic [3:0]  chid;
        logic [15:0] val;
        int          reps;
        logic [7:0]  adrs;
        logic [31:0] exp;
    } vec_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [2:0]  id       = 3'd5;
    logic        en       = 1'b1;
    logic        mode     = 1'b0;
    logic        mode16   = 1'b0;
    logic        ev       = 1'b0;
    logic        ev16     = 1'b0;
    logic [3:0]  chid     = '0;
    logic [15:0] val      = '0;
    logic        clr      = 1'b0;
    logic [1:0]  clr_op   = '0;
    logic [3:0]  clr_chid = '0;
    logic [2:0]  clr_arr  = '0;
    logic [7:0]  adrs     = '0;
    logic [31:0] dout;
    logic [15:0] dout16, drop, drop16;
    logic        busy, busy16;
    int          n_run  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    zuc_histo_gen dut (
        .hist_clk         (clk),
        .hist_reset_n     (rst_n),
        .hist_id          (id),
        .hist_enable      (en),
        .hist_mode        (mode),
        .hist_event       (ev),
        .hist_event_chid  (chid),
        .hist_event_value (val),
        .hist_clear       (clr),
        .hist_clear_op    (clr_op),
        .hist_clear_chid  (clr_chid),
        .hist_clear_array (clr_arr),
        .hist_adrs        (adrs),
        .hist_dout        (dout),
        .hist_drop_cnt    (drop),
        .hist_busy        (busy)
    );

    zuc_histo_gen #(.CNT_W(16)) dut16 (
        .hist_clk         (clk),
        .hist_reset_n     (rst_n),
        .hist_id          (id),
        .hist_enable      (en),
        .hist_mode        (mode16),
        .hist_event       (ev16),
        .hist_event_chid  (chid),
        .hist_event_value (val),
        .hist_clear       (clr),
        .hist_clear_op    (clr_op),
        .hist_clear_chid  (clr_chid),
        .hist_clear_array (clr_arr),
        .hist_adrs        (adrs),
        .hist_dout        (dout16),
        .hist_drop_cnt    (drop16),
        .hist_busy        (busy16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] c, input logic [15:0] v,
                        input int reps, input logic to16);
        chid = c;
        val  = v;
        ev   = !to16;
        ev16 = to16;
        repeat (reps) tick();
        ev   = 1'b0;
        ev16 = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        adrs = a;
        tick();
    endtask

    task automatic pulse_clear(input logic [1:0] op, input logic [3:0] c,
                               input logic [2:0] arr);
        clr      = 1'b1;
        clr_op   = op;
        clr_chid = c;
        clr_arr  = arr;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        vec_t vt[11];
        int   bc, nz;
        vt[0]  = '{1'b0, 4'd3, 16'd0,     1, 8'h30, 32'd1};
        vt[1]  = '{1'b0, 4'd3, 16'd1,     1, 8'h31, 32'd1};
        vt[2]  = '{1'b0, 4'd3, 16'hFFFF,  1, 8'h3F, 32'd1};
        vt[3]  = '{1'b0, 4'd3, 16'd2,     1, 8'h32, 32'd1};
        vt[4]  = '{1'b0, 4'd3, 16'd3,     1, 8'h32, 32'd2};
        vt[5]  = '{1'b0, 4'd3, 16'd4,     1, 8'h33, 32'd1};
        vt[6]  = '{1'b0, 4'd3, 16'd16383, 1, 8'h3E, 32'd1};
        vt[7]  = '{1'b0, 4'd3, 16'd16384, 1, 8'h3F, 32'd2};
        vt[8]  = '{1'b1, 4'd5, 16'd100,   3, 8'h57, 32'd300};
        vt[9]  = '{1'b1, 4'd5, 16'd127,   1, 8'h57, 32'd427};
        vt[10] = '{1'b1, 4'd5, 16'd128,   2, 8'h58, 32'd256};

        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_drop", 64'(drop), 64'(0));
        check("rst_dout", 64'(dout), 64'(0));
        check("rst_busy16", 64'(busy16), 64'(0));
        rst_n = 1'b1;

        bc = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (busy) bc++;
            else if (bc > 0) break;
        end
        check("init_busy_cycles", 64'(bc), 64'(256));
        nz = 0;
        for (int a = 0; a < 256; a++) begin
            rd(8'(a));
            if (dout !== 32'd0) nz++;
            if (dout16 !== 16'd0) nz++;
        end
        check("init_all_zero", 64'(nz), 64'(0));

        for (int i = 0; i < 11; i++) begin
            mode = vt[i].mode;
            send(vt[i].chid, vt[i].val, vt[i].reps, 1'b0);
            repeat (3 * vt[i].reps + 6) tick();
            rd(vt[i].adrs);
            check($sformatf("vec%0d", i), 64'(dout), 64'(vt[i].exp));
        end
        check("no_drops", 64'(drop), 64'(0));

        mode = 1'b0;
        send(4'd2, 16'd5, 1, 1'b0);
        send(4'd7, 16'd5, 1, 1'b0);
        repeat (10) tick();
        pulse_clear(HIST_OP_CLEAR_CHID, 4'd2, 3'd4);
        bc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy) bc++;
        end
        check("chid_wrong_array_busy", 64'(bc), 64'(0));
        rd(8'h23);
        check("chid_wrong_array_keep", 64'(dout), 64'(1));

        pulse_clear(HIST_OP_CLEAR_CHID, 4'd2, 3'd5);
        bc = 0;
        chid = 4'd2;
        val  = 16'd0;
        for (int i = 0; i < 60; i++) begin
            tick();
            ev = (bc == 0) && busy;
            if (busy) bc++;
            else if (bc > 0) break;
        end
        ev = 1'b0;
        check("chid_busy_cycles", 64'(bc), 64'(16));
        repeat (10) tick();
        rd(8'h20);
        check("chid_queued_event", 64'(dout), 64'(1));
        nz = 0;
        for (int a = 8'h21; a <= 8'h2F; a++) begin
            rd(8'(a));
            if (dout !== 32'd0) nz++;
        end
        check("chid_cleared", 64'(nz), 64'(0));
        rd(8'h73);
        check("chid7_untouched", 64'(dout), 64'(1));

        pulse_clear(HIST_OP_CLEAR_ALL, 4'd0, 3'd0);
        bc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy) begin
                bc = 1;
                break;
            end
        end
        check("all_busy_start", 64'(bc), 64'(1));
        send(4'd1, 16'd1, 41, 1'b0);
        check("all_drop_cnt", 64'(drop), 64'(8));
        repeat (350) tick();
        check("all_busy_done", 64'(busy), 64'(0));
        rd(8'h11);
        check("all_queued32", 64'(dout), 64'(32));
        rd(8'h73);
        check("all_cleared73", 64'(dout), 64'(0));
        check("all_drop_hold", 64'(drop), 64'(8));

        mode16 = 1'b1;
        send(4'd4, 16'hFFFE, 1, 1'b1);
        repeat (8) tick();
        rd(8'h4F);
        check("c16_preload", 64'(dout16), 64'(16'hFFFE));
        check("c16_other_dut", 64'(dout), 64'(0));
        mode16 = 1'b0;
        send(4'd4, 16'hFFFF, 3, 1'b1);
        repeat (15) tick();
        rd(8'h4F);
        check("c16_saturate", 64'(dout16), 64'(16'hFFFF));
        check("c16_no_drops", 64'(drop16), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/zuc_histo_gen.md
ZUC_HISTO_GEN -- requirements
Module: zuc_histo_gen

Interface
REQ-001 SHALL have parameter NUM_CHID, default 16, number of channels (power of 2, 2..64).
REQ-002 SHALL have parameter NUM_BKT, default 16, buckets per channel (power of 2, 4..32).
REQ-003 SHALL have parameter CNT_W, default 32, bucket counter width (16..48).
REQ-004 SHALL have parameter VAL_W, default 16, event value width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 32, event FIFO depth (power of 2).
REQ-006 SHALL have port: hist_clk  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port: hist_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port: hist_id  in  3  array identity for clear decode.
REQ-009 SHALL have port: hist_enable  in  1  gates event capture.
REQ-010 SHALL have port: hist_mode  in  1  0=count events, 1=accumulate event value; static between clears.
REQ-011 SHALL have ports: hist_event in 1 / hist_event_chid in log2(NUM_CHID) / hist_event_value in VAL_W  one-cycle update event.
REQ-012 SHALL have ports: hist_clear in 1 / hist_clear_op in 2 / hist_clear_chid in log2(NUM_CHID) / hist_clear_array in 3  one-cycle clear request.
REQ-013 SHALL have ports: hist_adrs in log2(NUM_CHID)+log2(NUM_BKT) / hist_dout out CNT_W  host read port, {chid,bucket}.
REQ-014 SHALL have port: hist_drop_cnt  out  16  events lost to FIFO full.
REQ-015 SHALL have port: hist_busy  out  1  high during any clear sweep.

Function
REQ-016 SHALL capture event into FIFO when hist_enable && hist_event && FIFO not full, every cycle (no one-cycle gap).
REQ-017 SHALL increment hist_drop_cnt (saturate 16'hFFFF) when hist_enable && hist_event && FIFO full.
REQ-018 SHALL map value: 0 -> bucket 0; value <= SIZE_BKT[k] -> smallest such k in 1..NUM_BKT-2; else bucket NUM_BKT-1.
REQ-019 SHALL run FSM IDLE -> RD -> UPD -> IDLE for an update, IDLE -> CLR -> IDLE for clears; FIFO popped on IDLE->RD.
REQ-020 SHALL in UPD write old+1 (mode 0) or old+zero-extended value (mode 1), saturating at all-ones of CNT_W.
REQ-021 SHALL give clear priority: pending clear_chid, then clear_all/post-reset sweep, then FIFO event, evaluated in IDLE only.
REQ-022 SHALL decode clear: op CLEAR_CHID & array==hist_id -> clear that chid's NUM_BKT entries; op CLEAR_ARRAY & array==hist_id, or op CLEAR_ALL -> clear all NUM_CHID*NUM_BKT entries.
REQ-023 SHALL hold one pending clear; a clear arriving while one is pending or sweeping SHALL be ignored.
REQ-024 SHALL clear one entry per cycle in CLR, sweep of N entries taking N cycles; hist_busy high for exactly those cycles.
REQ-025 SHALL flush FIFO and zero hist_drop_cnt in the first CLR cycle of a clear-all; events in that cycle are dropped uncounted, later ones accepted.
REQ-026 SHALL leave FIFO intact on clear_chid; queued events for that chid update after the sweep.
REQ-027 SHALL provide hist_dout = array[hist_adrs] with 1-cycle registered latency, independent of FSM.
REQ-028 SHALL present hist_dout value after the write completes when host read and UPD write target the same address in one cycle (write-first).

Reset
REQ-029 SHALL on hist_reset_n low: FSM IDLE, FIFO empty, hist_drop_cnt 0, hist_busy 0, hist_dout 0, pending clear 0.
REQ-030 SHALL after hist_reset_n deasserts, perform a full clear-all sweep (hist_busy 1) before servicing events.
REQ-031 SHALL on reset mid-sweep or mid-update abandon the operation; post-reset sweep restores all-zero contents.

Structure
REQ-032 SHALL take HIST_OP_CLEAR_CHID/ARRAY/ALL codes and SIZE_BKT threshold array (ascending) from shared zuc_params package.
REQ-033 SHALL instantiate sub-module zuc_histo_fifo (parametrised width/depth, show-ahead, async active-low reset); counter RAM inferred as simple dual-port.

Verification
REQ-034 SHALL test: after reset, read all 256 entries -> all 0, hist_busy high exactly 256 cycles.
REQ-035 SHALL test: mode 0, chid 3 values 0, 1, 70000-clamped 16'hFFFF -> adrs 0x30, 0x31, 0x3F each read 1.
REQ-036 SHALL test: mode 1, chid 5 value 100 x3 back-to-back -> bucket for 100 reads 300; no drops.
REQ-037 SHALL test: stall FSM with clear_all, burst 40 events -> 32 queued after flush cycle, hist_drop_cnt 8 (excluding flush-cycle event).
REQ-038 SHALL test: CNT_W=16 preload 16'hFFFE, 3 count events same bucket -> reads 16'hFFFF.
REQ-039 SHALL test: clear_chid 2 with hist_clear_array!=hist_id -> no change; matching -> entries 0x20..0x2F zero, chid 7 untouched.
